// File: rtl/aes_dec_sched.sv
// Two-requester scheduler in front of a shared AES decipher core:
// round-robin grant, job latching, core start handshake and result hand-off.
module aes_dec_sched #(
    localparam int unsigned BLK_W = 128,
    localparam int unsigned KL_W  = 2,
    localparam int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [BLK_W-1:0] in0_block,
    input  logic [KL_W-1:0]  in0_keylen,
    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [BLK_W-1:0] in1_block,
    input  logic [KL_W-1:0]  in1_keylen,
    output logic             core_next,
    output logic [KL_W-1:0]  core_keylen,
    output logic [BLK_W-1:0] core_block,
    input  logic             core_ready,
    input  logic [BLK_W-1:0] core_new_block,
    output logic             key_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] out_block,
    output logic             out_id,
    output logic             out_err,
    output logic [CNT_W-1:0] done_cnt
);

    localparam logic [KL_W-1:0] KL_BAD = KL_W'(3);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        ACK   = 3'd2,
        BUSY  = 3'd3,
        OUT   = 3'd4
    } state_t;

    state_t             state, state_nxt;
    logic               last_id;
    logic [BLK_W-1:0]   job_block;
    logic [KL_W-1:0]    job_keylen;
    logic               job_id;
    logic [CNT_W-1:0]   done_cnt_q;

    logic               grant_vld_c;
    logic               grant_id_c;
    logic               take_c;
    logic [BLK_W-1:0]   sel_block_c;
    logic [KL_W-1:0]    sel_keylen_c;

    // Round-robin pick: a tie goes to whoever was not served last.
    always_comb begin
        grant_vld_c = 1'b0;
        grant_id_c  = 1'b0;
        if (in0_valid && in1_valid) begin
            grant_vld_c = 1'b1;
            grant_id_c  = ~last_id;
        end else if (in0_valid) begin
            grant_vld_c = 1'b1;
            grant_id_c  = 1'b0;
        end else if (in1_valid) begin
            grant_vld_c = 1'b1;
            grant_id_c  = 1'b1;
        end
    end

    assign sel_block_c  = grant_id_c ? in1_block  : in0_block;
    assign sel_keylen_c = grant_id_c ? in1_keylen : in0_keylen;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Ready is gated with reset_n so a requester is never acknowledged while held in reset.
    always_comb begin
        state_nxt = state;
        take_c    = 1'b0;
        in0_ready = 1'b0;
        in1_ready = 1'b0;
        core_next = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                if (grant_vld_c && reset_n) begin
                    take_c    = 1'b1;
                    in0_ready = ~grant_id_c;
                    in1_ready = grant_id_c;
                    state_nxt = (sel_keylen_c == KL_BAD) ? OUT : START;
                end
            end
            START: begin
                core_next = 1'b1;
                state_nxt = ACK;
            end
            ACK: begin
                if (!core_ready) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (core_ready) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Job registers and result capture; the core sees only the latched job.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_id    <= 1'b1;
            job_block  <= '0;
            job_keylen <= '0;
            job_id     <= 1'b0;
            out_block  <= '0;
            out_id     <= 1'b0;
            out_err    <= 1'b0;
            done_cnt_q <= '0;
        end else begin
            if (take_c) begin
                job_block  <= sel_block_c;
                job_keylen <= sel_keylen_c;
                job_id     <= grant_id_c;
                last_id    <= grant_id_c;
                out_id     <= grant_id_c;
                if (sel_keylen_c == KL_BAD) begin
                    out_block <= '0;
                    out_err   <= 1'b1;
                end
            end
            if (state == BUSY && core_ready) begin
                out_block <= core_new_block;
                out_err   <= 1'b0;
            end
            if (state == OUT && out_ready) begin
                done_cnt_q <= done_cnt_q + CNT_W'(1);
            end
        end
    end

    assign core_block  = job_block;
    assign core_keylen = job_keylen;
    assign key_sel     = job_id;
    assign done_cnt    = done_cnt_q;

endmodule

// File: tb/tb_aes_dec_sched.sv
// Scoreboard bench for aes_dec_sched with a behavioural decipher-core model.
module tb_aes_dec_sched;

    localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;

    typedef struct packed {
        logic [127:0] block;
        logic [1:0]   keylen;
    } job_t;

    typedef struct packed {
        logic         id;
        logic         err;
        logic [127:0] block;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in0_valid = 1'b0, in1_valid = 1'b0;
    logic         in0_ready, in1_ready;
    logic [127:0] in0_block = '0, in1_block = '0;
    logic [1:0]   in0_keylen = '0, in1_keylen = '0;
    logic         core_next;
    logic [1:0]   core_keylen;
    logic [127:0] core_block;
    logic         core_ready;
    logic [127:0] core_new_block;
    logic         key_sel;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] out_block;
    logic         out_id;
    logic         out_err;
    logic [15:0]  done_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    aes_dec_sched dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .in0_valid      (in0_valid),
        .in0_ready      (in0_ready),
        .in0_block      (in0_block),
        .in0_keylen     (in0_keylen),
        .in1_valid      (in1_valid),
        .in1_ready      (in1_ready),
        .in1_block      (in1_block),
        .in1_keylen     (in1_keylen),
        .core_next      (core_next),
        .core_keylen    (core_keylen),
        .core_block     (core_block),
        .core_ready     (core_ready),
        .core_new_block (core_new_block),
        .key_sel        (key_sel),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_block      (out_block),
        .out_id         (out_id),
        .out_err        (out_err),
        .done_cnt       (done_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail(input string name);
        n_checks++;
        $display("FAIL %s: event not seen within bound", name);
    endtask

    // Core stand-in: FIPS-197 vector for the AES-128 case, otherwise a keyed scramble.
    function automatic logic [127:0] core_fn(input logic [127:0] blk, input logic [1:0] kl,
                                             input logic ks);
        if (blk == FIPS_CT && kl == 2'd0 && ks == 1'b0) return FIPS_PT;
        return ~blk ^ {125'd0, ks, kl};
    endfunction

    logic [127:0] core_res;
    int           core_cnt;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_ready     <= 1'b1;
            core_new_block <= '0;
            core_res       <= '0;
            core_cnt       <= 0;
        end else if (core_next) begin
            core_ready <= 1'b0;
            core_cnt   <= 4;
            core_res   <= core_fn(core_block, core_keylen, key_sel);
        end else if (!core_ready) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1) begin
                core_ready     <= 1'b1;
                core_new_block <= core_res;
            end
        end
    end

    job_t q0[$], q1[$];
    exp_t exp_out[$];
    logic exp_grant[$];
    logic take0 = 1'b0, take1 = 1'b0;

    task drive_inputs();
        in0_valid  = (q0.size() != 0);
        in0_block  = (q0.size() != 0) ? q0[0].block  : '0;
        in0_keylen = (q0.size() != 0) ? q0[0].keylen : '0;
        in1_valid  = (q1.size() != 0);
        in1_block  = (q1.size() != 0) ? q1[0].block  : '0;
        in1_keylen = (q1.size() != 0) ? q1[0].keylen : '0;
    endtask

    // Requester drivers: a job leaves its queue after the edge that accepted it.
    always @(negedge clk) begin
        take0 = in0_ready;
        take1 = in1_ready;
    end

    always @(posedge clk) begin
        #1;
        if (take0 && q0.size() != 0) void'(q0.pop_front());
        if (take1 && q1.size() != 0) void'(q1.pop_front());
        take0 = 1'b0;
        take1 = 1'b0;
        drive_inputs();
    end

    task automatic issue(input logic id, input logic [127:0] blk, input logic [1:0] kl);
        job_t j;
        exp_t e;
        j.block  = blk;
        j.keylen = kl;
        e.id     = id;
        e.err    = (kl == 2'd3);
        e.block  = (kl == 2'd3) ? 128'd0 : core_fn(blk, kl, id);
        if (id) q1.push_back(j);
        else    q0.push_back(j);
        exp_grant.push_back(id);
        exp_out.push_back(e);
    endtask

    // Monitor: grants, core start, result latency/stability and result handshakes.
    logic         prev_ov = 1'b0, prev_cr = 1'b1;
    logic [127:0] prev_blk;
    logic         prev_id, prev_err;
    int           grant_cyc = 0, rise_cyc = 0, core_next_cnt = 0;
    logic [1:0]   grant_kl;
    logic [127:0] grant_blk;
    logic         grant_id, gid;
    exp_t         e_mon;

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_ov = 1'b0;
            prev_cr = 1'b1;
        end else begin
            if (core_ready && !prev_cr) rise_cyc = cyc;
            prev_cr = core_ready;
            if (in0_ready || in1_ready) begin
                check("ready_exclusive", 128'(in0_ready && in1_ready), 128'd0);
                gid = in1_ready;
                if (exp_grant.size() == 0) fail("grant_unexpected");
                else check("grant_id", 128'(gid), 128'(exp_grant.pop_front()));
                grant_cyc = cyc;
                grant_id  = gid;
                grant_kl  = gid ? in1_keylen : in0_keylen;
                grant_blk = gid ? in1_block  : in0_block;
            end
            if (core_next) begin
                core_next_cnt++;
                check("core_next_latency", 128'(cyc), 128'(grant_cyc + 1));
                check("core_next_not_err_job", 128'(grant_kl == 2'd3), 128'd0);
                check("core_block", core_block, grant_blk);
                check("core_keylen", 128'(core_keylen), 128'(grant_kl));
                check("key_sel", 128'(key_sel), 128'(grant_id));
            end
            if (out_valid) begin
                check("ready_during_out", 128'(in0_ready || in1_ready), 128'd0);
                if (!prev_ov) begin
                    if (exp_out.size() != 0 && exp_out[0].err)
                        check("err_latency", 128'(cyc), 128'(grant_cyc + 1));
                    else
                        check("out_latency", 128'(cyc), 128'(rise_cyc + 1));
                end else begin
                    check("hold_block", out_block, prev_blk);
                    check("hold_id", 128'(out_id), 128'(prev_id));
                    check("hold_err", 128'(out_err), 128'(prev_err));
                end
                if (out_ready) begin
                    if (exp_out.size() == 0) fail("out_unexpected");
                    else begin
                        e_mon = exp_out.pop_front();
                        check("out_id", 128'(out_id), 128'(e_mon.id));
                        check("out_err", 128'(out_err), 128'(e_mon.err));
                        check("out_block", out_block, e_mon.block);
                    end
                end
            end
            prev_ov  = out_valid && !out_ready;
            prev_blk = out_block;
            prev_id  = out_id;
            prev_err = out_err;
        end
    end

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_out.size() != 0 || q0.size() != 0 || q1.size() != 0 || out_valid)
                   && n < 400);
        if (n >= 400) fail(name);
    endtask

    task automatic wait_out_valid(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 200);
        if (!out_valid) fail(name);
    endtask

    task automatic wait_core_next(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!core_next && n < 200);
        if (!core_next) fail(name);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 reset_n = 1'b0;
        q0.delete();
        q1.delete();
        exp_out.delete();
        exp_grant.delete();
        drive_inputs();
        @(posedge clk);
        @(posedge clk);
        #2 reset_n = 1'b1;
    endtask

    initial begin
        int cn_before;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_core_next", 128'(core_next), 128'd0);
        check("rst_in0_ready", 128'(in0_ready), 128'd0);
        check("rst_out_block", out_block, 128'd0);
        check("rst_out_id_err", 128'({out_id, out_err}), 128'd0);
        check("rst_done_cnt", 128'(done_cnt), 128'd0);
        check("rst_core_block", core_block, 128'd0);
        @(posedge clk);
        #2 reset_n = 1'b1;

        // FIPS-197 AES-128 vector from requester 0
        issue(1'b0, FIPS_CT, 2'd0);
        wait_idle("fips_done");
        check("fips_done_cnt", 128'(done_cnt), 128'd1);

        // Both requesters busy from reset: strict alternation starting at 0
        do_reset();
        issue(1'b0, 128'h000102030405060708090a0b0c0d0e0f, 2'd0);
        issue(1'b1, 128'hffeeddccbbaa99887766554433221100, 2'd1);
        issue(1'b0, 128'h0123456789abcdef0123456789abcdef, 2'd2);
        issue(1'b1, 128'hdeadbeefcafef00d0badc0de12345678, 2'd0);
        wait_idle("rr_done");
        check("rr_done_cnt", 128'(done_cnt), 128'd4);

        // Invalid keylen on requester 1 never reaches the core
        cn_before = core_next_cnt;
        issue(1'b1, 128'h55aa55aa55aa55aa55aa55aa55aa55aa, 2'd3);
        wait_idle("err_done");
        check("err_no_core_next", 128'(core_next_cnt), 128'(cn_before));
        check("err_done_cnt", 128'(done_cnt), 128'd5);

        // Output back-pressure with a second job waiting
        @(posedge clk);
        #2 out_ready = 1'b0;
        issue(1'b0, 128'hcafebabe00000000ffffffff12345678, 2'd2);
        wait_out_valid("bp_out_valid");
        issue(1'b0, 128'h0f0e0d0c0b0a09080706050403020100, 2'd1);
        repeat (20) begin
            @(negedge clk);
            check("bp_in0_ready_low", 128'(in0_ready), 128'd0);
            check("bp_out_valid_held", 128'(out_valid), 128'd1);
        end
        @(posedge clk);
        #2 out_ready = 1'b1;
        @(negedge clk);
        check("bp_no_grant_on_handshake", 128'(in0_ready), 128'd0);
        @(negedge clk);
        check("bp_grant_next_cycle", 128'(in0_ready), 128'd1);
        wait_idle("bp_done");
        check("bp_done_cnt", 128'(done_cnt), 128'd7);

        // Reset while the core is busy abandons the job
        issue(1'b1, 128'h11112222333344445555666677778888, 2'd1);
        wait_core_next("rst_mid_core_next");
        q0.push_back('{block: 128'h99990000aaaabbbbccccddddeeeeffff, keylen: 2'd2});
        @(negedge clk);
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("midrst_out_valid", 128'(out_valid), 128'd0);
        check("midrst_core_next", 128'(core_next), 128'd0);
        check("midrst_in0_ready", 128'(in0_ready), 128'd0);
        check("midrst_done_cnt", 128'(done_cnt), 128'd0);
        exp_out.delete();
        exp_grant.delete();
        exp_grant.push_back(1'b0);
        exp_out.push_back('{id: 1'b0, err: 1'b0,
                            block: core_fn(128'h99990000aaaabbbbccccddddeeeeffff, 2'd2, 1'b0)});
        @(posedge clk);
        #2 reset_n = 1'b1;
        wait_idle("midrst_done");
        check("midrst_done_cnt_after", 128'(done_cnt), 128'd1);

        // Counter wrap
        @(negedge clk);
        dut.done_cnt_q = 16'hfffe;
        issue(1'b0, 128'h0, 2'd3);
        wait_idle("wrap1_done");
        check("wrap_ffff", 128'(done_cnt), 128'h0ffff);
        issue(1'b1, 128'h0, 2'd3);
        wait_idle("wrap2_done");
        check("wrap_zero", 128'(done_cnt), 128'd0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/aes_dec_sched.md
AES_DEC_SCHED -- requirements
Module: aes_dec_sched

Interface
REQ-001 clk  input  1  clock; all state updates on rising edge.
REQ-002 reset_n  input  1  reset, asynchronous, active-low.
REQ-003 in0_valid / in1_valid  input  1 each  requester 0/1 has a block to decipher.
REQ-004 in0_ready / in1_ready  output  1 each  requester 0/1 handshake accepted this cycle.
REQ-005 in0_block / in1_block  input  128 each  ciphertext from requester 0/1.
REQ-006 in0_keylen / in1_keylen  input  2 each  key length: 0=128, 1=192, 2=256, 3=invalid.
REQ-007 core_next  output  1  start pulse to the shared decipher core.
REQ-008 core_keylen  output  2  key length to the core.
REQ-009 core_block  output  128  ciphertext to the core.
REQ-010 core_ready  input  1  core idle/done flag; resets to 1, drops the cycle after a next pulse.
REQ-011 core_new_block  input  128  core plaintext result.
REQ-012 key_sel  output  1  selects the round-key source (requester id) for the active job.
REQ-013 out_valid  output  1  result available.
REQ-014 out_ready  input  1  downstream accepts the result.
REQ-015 out_block  output  128  plaintext result.
REQ-016 out_id  output  1  requester id of the result.
REQ-017 out_err  output  1  job rejected because its keylen was 3.
REQ-018 done_cnt  output  16  count of completed result handshakes.

Function
REQ-019 FSM states: IDLE, START, ACK, BUSY, OUT.
REQ-020 IDLE arbitration:
- If exactly one in*_valid is high, grant that requester.
- If both are high, grant the requester not in last_id (round-robin).
REQ-021 Grant in IDLE:
- Assert in<g>_ready combinationally for that cycle only.
- Latch the block, keylen and id into job registers; update last_id to g.
REQ-022 in*_ready SHALL be 0 in every state other than IDLE, and never asserted for both requesters at once.
REQ-023 Grant with keylen 3:
- Go IDLE -> OUT with out_block=0 and out_err=1.
- Never assert core_next for that job.
REQ-024 Grant with a valid keylen: go IDLE -> START.
REQ-025 START:
- core_next=1 for exactly this one cycle.
- Then go to ACK.
REQ-026 ACK: wait until core_ready==0, then go to BUSY.
REQ-027 BUSY:
- Wait until core_ready==1.
- Then capture core_new_block into out_block, set out_err=0, go to OUT.
REQ-028 OUT:
- Hold out_valid=1; out_block, out_id and out_err stay stable.
- When out_ready=1: increment done_cnt (wraps 0xFFFF -> 0) and go to IDLE.
- No new grant in that cycle.
REQ-029 core_block, core_keylen and key_sel SHALL be driven from the job registers and stay stable from START through BUSY.
REQ-030 core_next SHALL be 0 in every state except START.
REQ-031 Input changes outside the grant cycle SHALL have no effect on the active job.
REQ-032 Latency for a valid job: grant cycle G, core_next at G+1, out_valid one cycle after the cycle in which core_ready returns to 1.
REQ-033 Error-job latency: out_valid at G+1.
REQ-034 out_ready while out_valid=0 SHALL be ignored.

Reset
REQ-035 On reset_n=0, immediately set:
- state=IDLE, last_id=1 (so requester 0 wins the first tie).
- job registers=0, out_block=0, out_id=0, out_err=0, done_cnt=0.
- All outputs deasserted (core_next, in*_ready, out_valid = 0).
REQ-036 Reset mid-job SHALL abandon the job with no result and no done_cnt change; the core is reset by the same reset_n.

Verification
REQ-037 in0_valid=1 with keylen=0 and the FIPS-197 AES-128 ciphertext, round keys supplied by a core model:
- Expect in0_ready for one cycle and core_next one cycle later.
- Expect out_valid, out_id=0, out_err=0, plaintext 00112233445566778899aabbccddeeff; done_cnt=1.
REQ-038 in0_valid and in1_valid high together from reset for four jobs:
- Grant order 0,1,0,1.
- out_id follows the same order; done_cnt=4.
REQ-039 in1_valid=1 with keylen=3:
- out_valid one cycle after the grant, out_err=1, out_block=0, out_id=1.
- core_next never asserted.
REQ-040 Hold out_ready=0 for 20 cycles during OUT while in0_valid=1:
- out_valid and out_block stay stable; in0_ready stays 0.
- Grant only in the cycle after out_ready=1.
REQ-041 Assert reset_n=0 during BUSY:
- All outputs drop immediately.
- After release, the next job completes normally and done_cnt counts from 0.
REQ-042 Preload done_cnt near 0xFFFF, complete 2 jobs -> done_cnt wraps 0xFFFF -> 0x0000.
